// File: rtl/udma_traffic_chk_tx.sv
// Self-checking sink for the uDMA TX channel: compares streamed words against an incrementing reference.
// Optional ready throttling for backpressure tests is enabled with `define UDMA_TRAFFIC_CHK_THROTTLE_EN.
module udma_traffic_chk_tx #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [31:0]      cfg_setup_i,
    input  logic [31:0]      tx_data_i,
    input  logic             tx_valid_i,
    output logic             tx_ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] err_count_o,
    output logic [7:0]       first_err_idx_o,
    output logic [31:0]      first_err_data_o
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'b00,
        ST_CHECK      = 2'b01,
        ST_WAIT_CLEAR = 2'b10
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] expected;
    logic [7:0]  word_cnt;
    logic        thr_ok;
    logic        start;
    logic        xfer;
    logic        last_word;
    logic        mismatch;
    logic        unused_cfg;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign unused_cfg = ^cfg_setup_i[7:1];

`ifdef UDMA_TRAFFIC_CHK_THROTTLE_EN
    logic [2:0] thr_cnt;

    always_comb begin
        case (cfg_setup_i[2:1])
            2'b00:   thr_ok = 1'b1;
            2'b01:   thr_ok = (thr_cnt[0] == 1'b0);
            2'b10:   thr_ok = (thr_cnt[1:0] == 2'b00);
            default: thr_ok = (thr_cnt == 3'd0);
        endcase
    end

    // Restarted on every start so the first CHECK cycle is always ready.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            thr_cnt <= 3'd0;
        end else if (start) begin
            thr_cnt <= 3'd0;
        end else if (state == ST_CHECK) begin
            thr_cnt <= thr_cnt + 3'd1;
        end
    end
`else
    assign thr_ok = 1'b1;
`endif

    assign start     = (state == ST_IDLE) && cfg_setup_i[0];
    assign xfer      = tx_valid_i && tx_ready_o;
    assign last_word = (word_cnt == cfg_setup_i[15:8]);
    assign mismatch  = (tx_data_i != expected);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        tx_ready_o = 1'b0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cfg_setup_i[0]) state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                busy_o     = 1'b1;
                tx_ready_o = thr_ok;
                // Enable is deliberately ignored here: the run always completes.
                if (tx_valid_i && thr_ok && last_word) state_nxt = ST_WAIT_CLEAR;
            end
            ST_WAIT_CLEAR: begin
                done_o = 1'b1;
                if (!cfg_setup_i[0]) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            expected         <= 32'd0;
            word_cnt         <= 8'd0;
            err_o            <= 1'b0;
            err_count_o      <= '0;
            first_err_idx_o  <= 8'd0;
            first_err_data_o <= 32'd0;
        end else if (start) begin
            expected         <= {16'h0000, cfg_setup_i[31:16]};
            word_cnt         <= 8'd0;
            err_o            <= 1'b0;
            err_count_o      <= '0;
            first_err_idx_o  <= 8'd0;
            first_err_data_o <= 32'd0;
        end else if (xfer) begin
            // Reference keeps counting regardless of received data (no resync).
            expected <= expected + 32'd1;
            word_cnt <= last_word ? 8'd0 : word_cnt + 8'd1;
            if (mismatch) begin
                err_count_o <= sat_inc(err_count_o);
                if (!err_o) begin
                    err_o            <= 1'b1;
                    first_err_idx_o  <= word_cnt;
                    first_err_data_o <= tx_data_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_udma_traffic_chk_tx.sv
// Randomised bench for udma_traffic_chk_tx with a transaction-level reference model.
// Throttle expectations follow `define UDMA_TRAFFIC_CHK_THROTTLE_EN.
module tb_udma_traffic_chk_tx;
    localparam int CNT_W   = 16;
    localparam int ERR_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic [31:0]      cfg = 32'd0;
    logic [31:0]      tx_data = 32'd0;
    logic             tx_valid = 1'b0;
    logic             tx_ready;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] err_count;
    logic [7:0]       first_err_idx;
    logic [31:0]      first_err_data;

    udma_traffic_chk_tx #(.CNT_W(CNT_W)) dut (
        .clk_i            (clk),
        .rstn_i           (rstn),
        .cfg_setup_i      (cfg),
        .tx_data_i        (tx_data),
        .tx_valid_i       (tx_valid),
        .tx_ready_o       (tx_ready),
        .busy_o           (busy),
        .done_o           (done),
        .err_o            (err),
        .err_count_o      (err_count),
        .first_err_idx_o  (first_err_idx),
        .first_err_data_o (first_err_data)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n_xfer = 0;
    int n_busy = 0;
    bit seen_done = 0;
    logic [31:0] wq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: run phase (0 idle, 1 checking, 2 finished) plus result registers.
    int          m_phase = 0;
    logic [31:0] m_exp = 32'd0;
    int          m_cnt = 0;
    bit          m_err = 0;
    int          m_ecnt = 0;
    int          m_fidx = 0;
    logic [31:0] m_fdata = 32'd0;
    int          m_thr = 0;

    function automatic bit m_ready();
        if (m_phase != 1) return 1'b0;
`ifdef UDMA_TRAFFIC_CHK_THROTTLE_EN
        case (cfg[2:1])
            2'd0:    return 1'b1;
            2'd1:    return (m_thr % 2) == 0;
            2'd2:    return (m_thr % 4) == 0;
            default: return m_thr == 0;
        endcase
`else
        return 1'b1;
`endif
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_phase <= 0; m_exp <= 32'd0; m_cnt <= 0; m_err <= 0;
            m_ecnt <= 0; m_fidx <= 0; m_fdata <= 32'd0; m_thr <= 0;
        end else begin
            case (m_phase)
                0: if (cfg[0]) begin
                    m_phase <= 1; m_exp <= {16'h0, cfg[31:16]}; m_cnt <= 0; m_err <= 0;
                    m_ecnt <= 0; m_fidx <= 0; m_fdata <= 32'd0; m_thr <= 0;
                end
                1: begin
                    m_thr <= (m_thr + 1) % 8;
                    if (tx_valid && m_ready()) begin
                        if (tx_data !== m_exp) begin
                            m_ecnt <= (m_ecnt < ERR_MAX) ? m_ecnt + 1 : m_ecnt;
                            if (!m_err) begin
                                m_err <= 1; m_fidx <= m_cnt; m_fdata <= tx_data;
                            end
                        end
                        m_exp <= m_exp + 32'd1;
                        if (m_cnt == int'(cfg[15:8])) begin
                            m_cnt <= 0; m_phase <= 2;
                        end else begin
                            m_cnt <= m_cnt + 1;
                        end
                    end
                end
                default: if (!cfg[0]) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("tx_ready", tx_ready, m_ready());
        chk("busy", busy, m_phase == 1);
        chk("done", done, m_phase == 2);
        chk("err", err, m_err);
        chk("err_count", err_count, m_ecnt);
        chk("first_err_idx", first_err_idx, m_fidx);
        chk("first_err_data", first_err_data, m_fdata);
        if (tx_valid && tx_ready) n_xfer++;
        if (busy) n_busy++;
        if (done) seen_done = 1;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic stream(input logic [31:0] c, input int valid_pct, input bit drop_en);
        int guard;
        bit hs;
        guard = 0;
        cfg = c;
        tick();
        while (wq.size() > 0 && guard < 5000) begin
            tx_data  = wq[0];
            tx_valid = ($urandom_range(99) < valid_pct);
            if (drop_en && wq.size() <= 2) cfg[0] = 1'b0;
            @(negedge clk);
            hs = tx_valid && tx_ready;
            tick();
            if (hs) void'(wq.pop_front());
            guard++;
        end
        tx_valid = 1'b0;
        if (guard >= 5000) chk("stream_timeout", 1, 0);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk(name, done, 1);
    endtask

    task automatic finish_run();
        cfg = 32'd0;
        tick();
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] v;
        int n;
        // Reset with valid asserted.
        tx_valid = 1'b1;
        tx_data  = 32'h1234;
        tick(); tick(); tick();
        chk("rst_ready", tx_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_xfers", n_xfer, 0);
        rstn = 1'b1;
        tick();
        tx_valid = 1'b0;
        tick();

        // Clean four-word run.
        wq = {32'd5, 32'd6, 32'd7, 32'd8};
        n_xfer = 0;
        stream(32'h0005_0301, 100, 0);
        wait_done("t1_done");
        chk("t1_xfers", n_xfer, 4);
        chk("t1_err", err, 0);
        chk("t1_err_count", err_count, 0);
        finish_run();
        chk("t1_done_cleared", done, 0);

        // Two mismatches, first at index 2.
        wq = {32'h10, 32'h11, 32'hAA, 32'h13, 32'hBB};
        stream(32'h0010_0401, 100, 0);
        wait_done("t2_done");
        chk("t2_err_count", err_count, 2);
        chk("t2_first_idx", first_err_idx, 2);
        chk("t2_first_data", first_err_data, 32'hAA);
        finish_run();
        chk("t2_hold_count", err_count, 2);
        chk("t2_hold_err", err, 1);

        // Full 256-word run.
        wq.delete();
        for (int i = 0; i < 256; i++) wq.push_back(32'h0000_FFFF + i);
        n_xfer = 0;
        stream(32'hFFFF_FF01, 100, 0);
        wait_done("t3_done");
        chk("t3_xfers", n_xfer, 256);
        chk("t3_err", err, 0);
        finish_run();

        // Random valid, random corruption, enable dropped mid-run.
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 40);
            v = $urandom_range(0, 65535);
            wq.delete();
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(4) == 0) wq.push_back((v + i) ^ $urandom_range(1, 255));
                else wq.push_back(v + i);
            end
            seen_done = 0;
            n_xfer = 0;
            stream({v[15:0], 8'(n - 1), 8'h01}, 60, 1);
            tick(); tick(); tick();
            chk("rnd_done_seen", seen_done, 1);
            chk("rnd_xfers", n_xfer, n);
            finish_run();
        end
        wq = {32'h0042, 32'h0043, 32'h0044};
        stream(32'h0042_0201, 100, 0);
        wait_done("restart_done");
        chk("restart_err_count", err_count, 0);
        finish_run();

        // Asynchronous reset in the middle of a failing run.
        tx_data  = 32'hDEAD;
        tx_valid = 1'b1;
        cfg      = 32'h0000_0901;
        tick(); tick(); tick(); tick();
        rstn = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_ready", tx_ready, 0);
        chk("arst_err_count", err_count, 0);
        tick();
        tx_valid = 1'b0;
        cfg = 32'd0;
        rstn = 1'b1;
        tick();

        // Throttle select 10: ready one cycle in four.
        wq = {32'd0, 32'd1, 32'd2, 32'd3};
        n_xfer = 0;
        n_busy = 0;
        stream(32'h0000_0305, 100, 0);
        wait_done("thr_done");
        chk("thr_xfers", n_xfer, 4);
        chk("thr_err", err, 0);
`ifdef UDMA_TRAFFIC_CHK_THROTTLE_EN
        chk("thr_check_cycles", n_busy, 13);
`else
        chk("thr_check_cycles", n_busy, 4);
`endif
        finish_run();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
